// File: rtl/status_reg_if.sv
// Signal bundle between the 6502 core/ALU and the processor status register.
// The core side drives strobes and ALU flags; the register side returns the stored status.
interface status_reg_if;
  logic       en;
  logic       alu_cout;
  logic       alu_overflow;
  logic       alu_zero;
  logic       alu_negative;
  logic       upd_nz;
  logic       upd_c;
  logic       upd_v;
  logic [2:0] flag_op;
  logic       bit_op;
  logic       load_p;
  logic [7:0] data_in;
  logic       irq_set;
  logic       instr_done;
  logic       push_brk;
  logic [7:0] p;
  logic [7:0] p_push;
  logic       carry;
  logic       dec_mode;
  logic       irq_mask;

  // Strobes are level-qualified by en: a strobe takes effect only on a rising
  // clock edge where en=1, with no request/acknowledge handshake.
  modport master (
    output en, alu_cout, alu_overflow, alu_zero, alu_negative,
    output upd_nz, upd_c, upd_v, flag_op, bit_op, load_p, data_in,
    output irq_set, instr_done, push_brk,
    input  p, p_push, carry, dec_mode, irq_mask
  );

  modport slave (
    input  en, alu_cout, alu_overflow, alu_zero, alu_negative,
    input  upd_nz, upd_c, upd_v, flag_op, bit_op, load_p, data_in,
    input  irq_set, instr_done, push_brk,
    output p, p_push, carry, dec_mode, irq_mask
  );
endinterface

// File: rtl/status_reg.sv
// 6502 processor status register: six stored flags, per-flag priority update,
// push formatting and the one-instruction-delayed IRQ mask.
module status_reg #(
  parameter logic RESET_I = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  status_reg_if.slave sif
);

  localparam logic [2:0] FOP_SEC = 3'd1;
  localparam logic [2:0] FOP_CLC = 3'd2;
  localparam logic [2:0] FOP_SEI = 3'd3;
  localparam logic [2:0] FOP_CLI = 3'd4;
  localparam logic [2:0] FOP_SED = 3'd5;
  localparam logic [2:0] FOP_CLD = 3'd6;
  localparam logic [2:0] FOP_CLV = 3'd7;

  logic n_q, v_q, d_q, i_q, z_q, c_q;
  logic irq_mask_q;
  logic n_d, v_d, d_d, i_d, z_d, c_d;
  logic irq_mask_d;

  logic sec, clc, sei, cli, sed, cld, clv;

  always_comb begin
    sec = 1'b0;
    clc = 1'b0;
    sei = 1'b0;
    cli = 1'b0;
    sed = 1'b0;
    cld = 1'b0;
    clv = 1'b0;
    case (sif.flag_op)
      FOP_SEC: sec = 1'b1;
      FOP_CLC: clc = 1'b1;
      FOP_SEI: sei = 1'b1;
      FOP_CLI: cli = 1'b1;
      FOP_SED: sed = 1'b1;
      FOP_CLD: cld = 1'b1;
      FOP_CLV: clv = 1'b1;
      default: ;
    endcase
  end

  // Each flag resolves its own priority chain; load_p always wins.
  always_comb begin
    n_d = n_q;
    v_d = v_q;
    d_d = d_q;
    i_d = i_q;
    z_d = z_q;
    c_d = c_q;
    if (sif.en) begin
      if (sif.load_p)      n_d = sif.data_in[7];
      else if (sif.bit_op) n_d = sif.data_in[7];
      else if (sif.upd_nz) n_d = sif.alu_negative;

      if (sif.load_p)      v_d = sif.data_in[6];
      else if (sif.bit_op) v_d = sif.data_in[6];
      else if (clv)        v_d = 1'b0;
      else if (sif.upd_v)  v_d = sif.alu_overflow;

      if (sif.load_p)      d_d = sif.data_in[3];
      else if (sed)        d_d = 1'b1;
      else if (cld)        d_d = 1'b0;

      if (sif.load_p)       i_d = sif.data_in[2];
      else if (sif.irq_set) i_d = 1'b1;
      else if (sei)         i_d = 1'b1;
      else if (cli)         i_d = 1'b0;

      if (sif.load_p)      z_d = sif.data_in[1];
      else if (sif.bit_op) z_d = sif.alu_zero;
      else if (sif.upd_nz) z_d = sif.alu_zero;

      if (sif.load_p)      c_d = sif.data_in[0];
      else if (sec)        c_d = 1'b1;
      else if (clc)        c_d = 1'b0;
      else if (sif.upd_c)  c_d = sif.alu_cout;
    end
  end

  // Polling sees I as it stood before this edge, giving the 6502's
  // one-instruction delay after CLI/SEI/PLP; interrupt entry masks at once.
  always_comb begin
    irq_mask_d = irq_mask_q;
    if (sif.en) begin
      if (sif.irq_set)         irq_mask_d = 1'b1;
      else if (sif.instr_done) irq_mask_d = i_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q        <= 1'b0;
      v_q        <= 1'b0;
      d_q        <= 1'b0;
      i_q        <= RESET_I;
      z_q        <= 1'b0;
      c_q        <= 1'b0;
      irq_mask_q <= RESET_I;
    end else begin
      n_q        <= n_d;
      v_q        <= v_d;
      d_q        <= d_d;
      i_q        <= i_d;
      z_q        <= z_d;
      c_q        <= c_d;
      irq_mask_q <= irq_mask_d;
    end
  end

  assign sif.p        = {n_q, v_q, 1'b1, 1'b0, d_q, i_q, z_q, c_q};
  assign sif.p_push   = {n_q, v_q, 1'b1, sif.push_brk, d_q, i_q, z_q, c_q};
  assign sif.carry    = c_q;
  assign sif.dec_mode = d_q;
  assign sif.irq_mask = irq_mask_q;

  // Bits 5 and 4 of a pulled status byte have no storage behind them.
  logic unused_data_bits;
  assign unused_data_bits = ^sif.data_in[5:4];

endmodule

// File: tb/tb_status_reg.sv
// Self-checking bench for status_reg: directed scenarios with literal
// expectations plus randomized traffic against a byte-level reference model.
module tb_status_reg;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  status_reg_if sif ();

  status_reg #(.RESET_I(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (sif)
  );

  int checks = 0;
  int errors = 0;

  // Expected {irq_mask, p} after each edge, produced by the model.
  logic [8:0] exp_q[$];
  logic [7:0] m_p;
  logic       m_mask;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: status held as the visible byte; sources are applied
  // lowest priority first so higher-priority sources overwrite them.
  always @(posedge clk or negedge rst_n) begin
    logic [7:0] nxt;
    logic       nmask;
    if (!rst_n) begin
      m_p    = 8'h24;
      m_mask = 1'b1;
      exp_q.delete();
      exp_q.push_back({m_mask, m_p});
    end else begin
      nxt   = m_p;
      nmask = m_mask;
      if (sif.en) begin
        if (sif.upd_c) nxt[0] = sif.alu_cout;
        if (sif.upd_v) nxt[6] = sif.alu_overflow;
        if (sif.upd_nz) begin
          nxt[7] = sif.alu_negative;
          nxt[1] = sif.alu_zero;
        end
        case (sif.flag_op)
          3'd1: nxt[0] = 1'b1;
          3'd2: nxt[0] = 1'b0;
          3'd3: nxt[2] = 1'b1;
          3'd4: nxt[2] = 1'b0;
          3'd5: nxt[3] = 1'b1;
          3'd6: nxt[3] = 1'b0;
          3'd7: nxt[6] = 1'b0;
          default: ;
        endcase
        if (sif.bit_op) begin
          nxt[7] = sif.data_in[7];
          nxt[6] = sif.data_in[6];
          nxt[1] = sif.alu_zero;
        end
        if (sif.irq_set) nxt[2] = 1'b1;
        if (sif.load_p) nxt = (sif.data_in & 8'hCF) | 8'h20;
        if (sif.instr_done) nmask = m_p[2];
        if (sif.irq_set) nmask = 1'b1;
      end
      m_p    = nxt;
      m_mask = nmask;
      exp_q.push_back({m_mask, m_p});
    end
  end

  // Compare process: every falling edge, against the model's latest state.
  always @(negedge clk) begin
    logic [8:0] e;
    logic [7:0] e_push;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      e_push = {e[7:5], sif.push_brk, e[3:0]};
      chk("p", sif.p, e[7:0]);
      chk("p_push", sif.p_push, e_push);
      chk("carry", {7'd0, sif.carry}, {7'd0, e[0]});
      chk("dec_mode", {7'd0, sif.dec_mode}, {7'd0, e[3]});
      chk("irq_mask", {7'd0, sif.irq_mask}, {7'd0, e[8]});
    end
  end

  task automatic clear();
    sif.en           = 1'b1;
    sif.alu_cout     = 1'b0;
    sif.alu_overflow = 1'b0;
    sif.alu_zero     = 1'b0;
    sif.alu_negative = 1'b0;
    sif.upd_nz       = 1'b0;
    sif.upd_c        = 1'b0;
    sif.upd_v        = 1'b0;
    sif.flag_op      = 3'd0;
    sif.bit_op       = 1'b0;
    sif.load_p       = 1'b0;
    sif.data_in      = 8'h00;
    sif.irq_set      = 1'b0;
    sif.instr_done   = 1'b0;
    sif.push_brk     = 1'b0;
  endtask

  // Inputs change just after a falling edge, far from the rising edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic fop(input logic [2:0] op);
    clear();
    sif.flag_op = op;
    tick();
  endtask

  initial begin
    clear();
    sif.en = 1'b0;
    repeat (2) tick();
    chk("reset_p", sif.p, 8'h24);
    chk("reset_mask", {7'd0, sif.irq_mask}, 8'h01);
    rst_n = 1'b1;
    clear();
    sif.push_brk = 1'b1;
    tick();
    chk("push_after_reset", sif.p_push, 8'h34);

    // ALU capture, all three update strobes
    clear();
    {sif.alu_cout, sif.alu_zero, sif.alu_negative, sif.alu_overflow} = 4'b1101;
    {sif.upd_nz, sif.upd_c, sif.upd_v} = 3'b111;
    tick();
    chk("alu_all_p", sif.p, 8'h67);
    chk("alu_all_carry", {7'd0, sif.carry}, 8'h01);
    fop(3'd2);
    fop(3'd7);
    chk("clc_clv_p", sif.p, 8'h26);
    clear();
    {sif.alu_cout, sif.alu_zero, sif.alu_negative, sif.alu_overflow} = 4'b1011;
    sif.upd_nz = 1'b1;
    tick();
    chk("alu_nz_only_p", sif.p, 8'hA4);

    // Priority: load_p beats flag_op and upd_c; en=0 freezes everything
    clear();
    sif.load_p = 1'b1;
    sif.data_in = 8'hC3;
    sif.flag_op = 3'd1;
    sif.upd_c = 1'b1;
    tick();
    chk("load_p_prio", sif.p, 8'hE3);
    clear();
    sif.en = 1'b0;
    sif.flag_op = 3'd2;
    sif.irq_set = 1'b1;
    sif.load_p = 1'b1;
    tick();
    chk("en_low_hold", sif.p, 8'hE3);
    chk("en_low_mask", {7'd0, sif.irq_mask}, 8'h01);

    // BIT
    clear();
    sif.data_in = 8'h40;
    sif.alu_zero = 1'b1;
    sif.bit_op = 1'b1;
    tick();
    chk("bit_p", sif.p, 8'h63);

    // Delayed interrupt mask
    fop(3'd3);
    chk("sei_p", sif.p, 8'h67);
    clear();
    sif.flag_op = 3'd4;
    sif.instr_done = 1'b1;
    tick();
    chk("cli_p", sif.p, 8'h63);
    chk("cli_mask_delayed", {7'd0, sif.irq_mask}, 8'h01);
    clear();
    sif.instr_done = 1'b1;
    tick();
    chk("mask_follows", {7'd0, sif.irq_mask}, 8'h00);
    clear();
    sif.irq_set = 1'b1;
    sif.upd_c = 1'b1;
    tick();
    chk("irq_set_p", sif.p, 8'h66);
    chk("irq_set_mask", {7'd0, sif.irq_mask}, 8'h01);

    // Push formatting
    clear();
    sif.load_p = 1'b1;
    sif.data_in = 8'h91;
    tick();
    chk("push_p", sif.p, 8'hA1);
    chk("push_b0", sif.p_push, 8'hA1);
    sif.push_brk = 1'b1;
    #1;
    chk("push_b1", sif.p_push, 8'hB1);
    chk("push_p_b1", sif.p, 8'hA1);

    // Asynchronous reset mid-cycle
    fop(3'd5);
    chk("sed_dec", {7'd0, sif.dec_mode}, 8'h01);
    clear();
    sif.upd_c = 1'b1;
    sif.alu_cout = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_p", sif.p, 8'h24);
    chk("async_carry", {7'd0, sif.carry}, 8'h00);
    chk("async_mask", {7'd0, sif.irq_mask}, 8'h01);
    tick();
    rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      sif.en           = ($urandom_range(0, 3) != 0);
      sif.alu_cout     = $urandom_range(0, 1);
      sif.alu_overflow = $urandom_range(0, 1);
      sif.alu_zero     = $urandom_range(0, 1);
      sif.alu_negative = $urandom_range(0, 1);
      sif.upd_nz       = $urandom_range(0, 1);
      sif.upd_c        = $urandom_range(0, 1);
      sif.upd_v        = $urandom_range(0, 1);
      sif.flag_op      = 3'($urandom_range(0, 7));
      sif.bit_op       = ($urandom_range(0, 5) == 0);
      sif.load_p       = ($urandom_range(0, 7) == 0);
      sif.data_in      = 8'($urandom_range(0, 255));
      sif.irq_set      = ($urandom_range(0, 7) == 0);
      sif.instr_done   = ($urandom_range(0, 2) == 0);
      sif.push_brk     = $urandom_range(0, 1);
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 199) == 0) begin
        #($urandom_range(1, 3));
        rst_n = 1'b0;
      end
      tick();
    end
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/status_reg.md
Name: status_reg

Overview:
- Processor status register (P) for the 6502 core.
- Sits directly downstream of the ALU:
  - captures the ALU flag outputs (carry-out, overflow, zero, negative) under per-instruction update strobes;
  - returns the stored carry to the ALU carry-in.
- Also handles:
  - explicit flag instructions (SEC/CLC/SEI/CLI/SED/CLD/CLV);
  - PLP/RTI loads and BIT flag loads;
  - PHP/BRK push formatting;
  - the one-instruction-delayed interrupt mask used by IRQ polling.

Parameters:
- RESET_I, 1, value of the I flag and irq_mask out of reset.

Ports:
- clk  in  1  core clock, all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- en  in  1  core ready; when 0 all state holds and all strobes are ignored.
- alu_cout  in  1  ALU carry-out.
- alu_overflow  in  1  ALU overflow.
- alu_zero  in  1  ALU zero.
- alu_negative  in  1  ALU negative.
- upd_nz  in  1  load N,Z from ALU this cycle.
- upd_c  in  1  load C from alu_cout this cycle.
- upd_v  in  1  load V from alu_overflow this cycle.
- flag_op  in  3  0 NOP, 1 SEC, 2 CLC, 3 SEI, 4 CLI, 5 SED, 6 CLD, 7 CLV.
- bit_op  in  1  BIT instruction: N<=data_in[7], V<=data_in[6], Z<=alu_zero.
- load_p  in  1  PLP/RTI: load flags from data_in.
- data_in  in  8  data bus value for load_p / bit_op.
- irq_set  in  1  interrupt/BRK entry: force I=1.
- instr_done  in  1  last cycle of current instruction (IRQ poll point).
- push_brk  in  1  B value to insert into p_push (1 for PHP/BRK, 0 for IRQ/NMI).
- p  out  8  current status {N,V,1,0,D,I,Z,C}.
- p_push  out  8  {N,V,1,push_brk,D,I,Z,C}, combinational from stored flags.
- carry  out  1  stored C, to ALU cin.
- dec_mode  out  1  stored D.
- irq_mask  out  1  effective I for IRQ polling.

Behaviour:
- Storage: six flop bits N,V,D,I,Z,C. Bit 5 always reads 1. Bit 4 is not stored; it reads 0 in p.
- Reset (async, rst_n=0):
  - N=V=D=Z=C=0, I=RESET_I;
  - p=8'h24 with RESET_I=1;
  - irq_mask=RESET_I;
  - carry=0, dec_mode=0.
- Release is synchronous to clk; first update on the first rising edge with rst_n=1.
- All outputs derive from stored flags, so an update is visible on outputs one cycle after the strobe edge. carry seen by the ALU is always the pre-instruction value.
- en=0: no flag or irq_mask change regardless of strobes.
- Per-flag priority when several sources target the same flag in one en cycle (highest first):
  - load_p (all six flags from data_in bits 7,6,3,2,1,0; bits 5,4 ignored);
  - irq_set (I only);
  - bit_op (N,V,Z);
  - flag_op;
  - upd_nz / upd_c / upd_v.
- Flags not targeted by the winning source keep their value or take a lower-priority source. Example: load_p wins every flag; irq_set + upd_c loads both I=1 and C.
- flag_op=NOP and all upd_* low: flags hold.
- irq_mask update:
  - on an en cycle with instr_done=1, irq_mask <= I as stored before this edge, i.e. the pre-update value;
  - so a CLI/SEI/PLP ending an instruction affects polling only after the following instruction completes (6502 one-instruction delay);
  - irq_set forces irq_mask=1 on the same edge, overriding instr_done;
  - otherwise irq_mask holds.
- Reset mid-instruction: immediate async return to reset values; in-flight strobes are lost.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> p=8'h24, carry=0, irq_mask=1 without waiting for a clock edge. After release, p_push with push_brk=1 = 8'h34.
- ALU capture: alu_cout=1, alu_zero=1, alu_negative=0, alu_overflow=1 with upd_nz=upd_c=upd_v=1 -> next cycle p=8'h67, carry=1. Same stimulus with only upd_nz -> C,V unchanged.
- Priority: load_p=1, data_in=8'hC3, flag_op=SEC, upd_c=1, alu_cout=0 in one cycle -> p=8'hE3. Then en=0 with flag_op=CLC -> p stays 8'hE3.
- BIT: data_in=8'h40, alu_zero=1, bit_op=1 -> N=0, V=1, Z=1, C unchanged.
- I delay: from I=1, CLI with instr_done=1 -> I=0, irq_mask=1. Next instr_done -> irq_mask=0. Then irq_set -> I=1, irq_mask=1 same edge.
- Push format: flags N=1, C=1, others 0 with push_brk=0 -> p_push=8'hA1. With push_brk=1 -> 8'hB1. p=8'hA1 in both cases.
